// File: rtl/comp_arith_pkg.sv
// Shared definitions for the PA1 arithmetic unit (CompMultiplier and comp_divider).
// Holds the common FSM state encoding and the default operand/counter widths.
package comp_arith_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comp_div_step.sv
// One restoring-division iteration: shift {R,Q} left by one and try to subtract the divisor.
import comp_arith_pkg::*;

module comp_div_step #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_remNext,
    output logic [WIDTH-1:0] o_quoNext
);

    logic [WIDTH:0] w_shift;
    logic           w_fits;

    // The shifted remainder is WIDTH+1 bits so divisors at or above 2^(WIDTH-1) cannot overflow.
    assign w_shift   = {i_rem, i_quo[WIDTH-1]};
    assign w_fits    = (w_shift >= {1'b0, i_divisor});
    assign o_remNext = w_fits ? WIDTH'(w_shift - {1'b0, i_divisor}) : w_shift[WIDTH-1:0];
    assign o_quoNext = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/comp_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with the
// Run/Ready handshake used by CompMultiplier. Result_out = {Remainder, Quotient}.
import comp_arith_pkg::*;

module comp_divider #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic [WIDTH-1:0]     Dividend_in,
    input  logic [WIDTH-1:0]     Divisor_in,
    output logic [2*WIDTH-1:0]   Result_out,
    output logic                 Ready,
    output logic                 DivZero
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;
    logic               r_divZero;

    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quoNext;

    comp_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_quo    (r_quo),
        .i_divisor(r_divisor),
        .o_remNext(w_remNext),
        .o_quoNext(w_quoNext)
    );

    // Result_out is only written on the finishing edge, so it never shows partial work.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    if (Run) begin
                        r_divisor <= Divisor_in;
                        r_rem     <= '0;
                        r_quo     <= Dividend_in;
                        r_divZero <= (Divisor_in == '0);
                        r_count   <= '0;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_rem   <= w_remNext;
                    r_quo   <= w_quoNext;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(WIDTH - 1)) begin
                        r_result <= {w_remNext, w_quoNext};
                        r_ready  <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!Run) begin
                        r_ready <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Result_out = r_result;
    assign Ready      = r_ready;
    assign DivZero    = r_divZero;

endmodule

// File: tb/tb_comp_divider.sv
// Self-checking bench for comp_divider: table-driven divisions plus hand-written
// sequences for mid-operation reset, input changes during CALC and the DONE handshake.
module tb_comp_divider;

    logic        clk;
    logic        Reset;
    logic        Run;
    logic [31:0] Dividend_in;
    logic [31:0] Divisor_in;
    logic [63:0] Result_out;
    logic        Ready;
    logic        DivZero;

    int checks;
    int failures;

    typedef struct {
        string       name;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [63:0] expResult;
        logic        expDivZero;
    } vec_t;

    vec_t vectors[7];

    comp_divider #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Run        (Run),
        .Dividend_in(Dividend_in),
        .Divisor_in (Divisor_in),
        .Result_out (Result_out),
        .Ready      (Ready),
        .DivZero    (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against the bench's own expected value.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents operands with Run high for a start edge, then counts edges until Ready (bounded).
    task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs, output int lat);
        @(negedge clk);
        Dividend_in = dvd;
        Divisor_in  = dvs;
        Run         = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!Ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Drops Run so the divider leaves DONE and returns to IDLE.
    task automatic releaseRun();
        @(negedge clk);
        Run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        logic [63:0] held;

        checks   = 0;
        failures = 0;

        vectors[0] = '{"100div7",      32'd100,        32'd7,          64'h00000002_0000000E, 1'b0};
        vectors[1] = '{"maxdiv1",      32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 1'b0};
        vectors[2] = '{"maxdivhalf",   32'hFFFFFFFF,   32'h80000000,   64'h7FFFFFFF_00000001, 1'b0};
        vectors[3] = '{"5div0",        32'd5,          32'd0,          64'h00000005_FFFFFFFF, 1'b1};
        vectors[4] = '{"3div10",       32'd3,          32'd10,         64'h00000003_00000000, 1'b0};
        vectors[5] = '{"0div9",        32'd0,          32'd9,          64'h00000000_00000000, 1'b0};
        vectors[6] = '{"1000div3",     32'd1000,       32'd3,          64'h00000001_0000014D, 1'b0};

        Reset       = 1'b1;
        Run         = 1'b0;
        Dividend_in = '0;
        Divisor_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_result",  Result_out,     64'd0);
        checkOutput("reset_ready",   64'(Ready),     64'd0);
        checkOutput("reset_divzero", 64'(DivZero),   64'd0);
        @(negedge clk);
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vectors[i].dvd, vectors[i].dvs, lat);
            checkOutput({vectors[i].name, "_latency"}, 64'(lat),             64'd32);
            checkOutput({vectors[i].name, "_result"},  Result_out,           vectors[i].expResult);
            checkOutput({vectors[i].name, "_divzero"}, 64'(DivZero),         64'(vectors[i].expDivZero));
            releaseRun();
            checkOutput({vectors[i].name, "_idle"},    64'(Ready),           64'd0);
        end

        // Reset in the middle of a division wipes everything before the next edge.
        @(negedge clk);
        Dividend_in = 32'd1000;
        Divisor_in  = 32'd3;
        Run         = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        Reset = 1'b1;
        Run   = 1'b0;
        #1;
        checkOutput("midreset_result",  Result_out,   64'd0);
        checkOutput("midreset_ready",   64'(Ready),   64'd0);
        checkOutput("midreset_divzero", 64'(DivZero), 64'd0);
        @(negedge clk);
        Reset = 1'b0;
        applyStimulus(32'd1000, 32'd3, lat);
        checkOutput("rerun_latency", 64'(lat),   64'd32);
        checkOutput("rerun_result",  Result_out, 64'h00000001_0000014D);
        releaseRun();

        // Operand and Run changes during CALC must not disturb the running division.
        @(negedge clk);
        Dividend_in = 32'd50;
        Divisor_in  = 32'd6;
        Run         = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!Ready && lat < 40) begin
            @(negedge clk);
            if (lat == 3) begin
                Dividend_in = 32'd999;
                Run         = 1'b0;
            end
            if (lat == 5) begin
                Run        = 1'b1;
                Divisor_in = 32'd1;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("calcnoise_latency", 64'(lat),   64'd32);
        checkOutput("calcnoise_result",  Result_out, 64'h00000002_00000008);

        held = Result_out;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("hold_ready",  64'(Ready), 64'd1);
        checkOutput("hold_result", Result_out, held);

        releaseRun();
        checkOutput("after_done_ready",  64'(Ready), 64'd0);
        checkOutput("after_done_result", Result_out, 64'h00000002_00000008);

        applyStimulus(32'd81, 32'd9, lat);
        checkOutput("restart_latency", 64'(lat),   64'd32);
        checkOutput("restart_result",  Result_out, 64'h00000000_00000009);
        releaseRun();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
